// File: rtl/spi_mem_cmd_bridge.sv
// spi_mem_cmd_bridge: decodes a cs_n-framed SPI byte command stream into panel config registers,
// buffered frame-memory writes and frame-memory reads returned as a transmit byte stream.
module spi_mem_cmd_bridge #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_BYTES    = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     cs_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_wr_valid,
  output logic                     mem_rd_req,
  input  logic                     mem_full,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_rd_valid,
  output logic                     frame_buffer_select,
  output logic                     color_format,
  output logic [9:0]               pixels_per_row,
  output logic [3:0]               panel_rows,
  output logic                     overflow,
  output logic                     fifo_empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {IDLE, ADDR, WR_DATA, RD_WAIT_WR, RD_REQ, RD_WAIT, RD_SEND, CFG, DONE} state_t;
  state_t state_q, state_d;
  logic cs_meta_q, cs_q;
  logic [7:0] op_q, op_d, cnt_q, cnt_d, hi_q, hi_d, rlo_q, rlo_d, tx_q, tx_d;
  logic half_q, half_d, push_q, push_d, rsec_q, rsec_d, stat_q, stat_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic fbs_q, fbs_d, cf_q, cf_d, ovf_q, ovf_d, und_q, und_d;
  logic [9:0] ppr_q, ppr_d;
  logic [3:0] rows_q, rows_d;
  logic [ADDRESS_WIDTH-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fd_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] fc_q;
  logic rx, rd_req, pop, push_ok, rd_frame;
  assign rx = rx_valid && !cs_q;
  assign fifo_empty = fc_q == '0;
  assign rd_req = state_q == RD_REQ && !mem_full && !cs_q;
  assign pop = !fifo_empty && !mem_full && !rd_req;
  assign push_ok = push_q && (fc_q < (PW+1)'(FIFO_DEPTH) || pop);
  assign rd_frame = state_q == RD_WAIT_WR || state_q == RD_REQ || state_q == RD_WAIT;
  // Memory side is combinational from the FIFO head so a pop and its strobe share a cycle.
  assign mem_wr_valid = pop;
  assign mem_rd_req = rd_req;
  assign mem_addr = pop ? fa_q[rp_q] : rd_req ? addr_q : '0;
  assign mem_wdata = pop ? fd_q[rp_q] : '0;
  assign tx_data = tx_q;
  assign frame_buffer_select = fbs_q;
  assign color_format = cf_q;
  assign pixels_per_row = ppr_q;
  assign panel_rows = rows_q;
  assign overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    rlo_d = rlo_q;
    tx_d = tx_q;
    half_d = half_q;
    push_d = 1'b0;
    rsec_d = rsec_q;
    stat_d = 1'b0;
    addr_d = addr_q;
    word_d = word_q;
    fbs_d = fbs_q;
    cf_d = cf_q;
    ppr_d = ppr_q;
    rows_d = rows_q;
    und_d = und_q;
    ovf_d = ovf_q | (push_q & ~push_ok);
    if (push_q) addr_d = addr_q + ADDRESS_WIDTH'(1);
    if (stat_q) begin
      tx_d = {4'b0, und_q, ovf_q, fifo_empty, fbs_q};
      ovf_d = push_q & ~push_ok;
      und_d = 1'b0;
    end
    if (tx_ready && rd_frame && !cs_q) begin
      tx_d = 8'h00;
      und_d = 1'b1;
    end
    if (cs_q) begin
      state_d = IDLE;
      cnt_d = '0;
      half_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rx) begin
          op_d = rx_data;
          cnt_d = '0;
          half_d = 1'b0;
          case (rx_data)
            8'h0A, 8'h0B: begin
              state_d = ADDR;
              addr_d = '0;
            end
            8'h14, 8'h1E, 8'h28, 8'h32: state_d = CFG;
            8'h3C: begin
              state_d = DONE;
              stat_d = 1'b1;
            end
            default: state_d = DONE;
          endcase
        end
        ADDR: if (rx) begin
          addr_d = ADDRESS_WIDTH'({addr_q, rx_data});
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(ADDR_BYTES - 1)) begin
            cnt_d = '0;
            state_d = op_q == 8'h0A ? WR_DATA : RD_WAIT_WR;
          end
        end
        WR_DATA: if (rx) begin
          if (!cf_q) begin
            push_d = 1'b1;
            word_d = DATA_WIDTH'(rx_data);
          end else if (!half_q) begin
            hi_d = rx_data;
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            push_d = 1'b1;
            word_d = DATA_WIDTH'({hi_q, rx_data});
          end
        end
        RD_WAIT_WR: if (fifo_empty && !push_q) state_d = RD_REQ;
        RD_REQ: if (!mem_full) state_d = RD_WAIT;
        RD_WAIT: if (mem_rd_valid) begin
          rlo_d = mem_rdata[7:0];
          rsec_d = cf_q;
          tx_d = cf_q ? mem_rdata[15:8] : mem_rdata[7:0];
          state_d = RD_SEND;
        end
        RD_SEND: if (tx_ready) begin
          if (rsec_q) begin
            tx_d = rlo_q;
            rsec_d = 1'b0;
          end else begin
            addr_d = addr_q + ADDRESS_WIDTH'(1);
            state_d = RD_REQ;
          end
        end
        CFG: if (rx) begin
          state_d = DONE;
          if (op_q == 8'h14) fbs_d = rx_data[0];
          if (op_q == 8'h1E) cf_d = rx_data[0];
          if (op_q == 8'h32) rows_d = rx_data[3:0];
          if (op_q == 8'h28 && cnt_q == '0) begin
            hi_d = rx_data;
            cnt_d = 8'd1;
            state_d = CFG;
          end else if (op_q == 8'h28) begin
            ppr_d = {hi_q[1:0], rx_data};
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cs_meta_q <= 1'b1;
      cs_q <= 1'b1;
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      rlo_q <= '0;
      tx_q <= '0;
      half_q <= 1'b0;
      push_q <= 1'b0;
      rsec_q <= 1'b0;
      stat_q <= 1'b0;
      addr_q <= '0;
      word_q <= '0;
      fbs_q <= 1'b0;
      cf_q <= 1'b0;
      ppr_q <= '0;
      rows_q <= 4'd1;
      ovf_q <= 1'b0;
      und_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
    end else begin
      cs_meta_q <= cs_n;
      cs_q <= cs_meta_q;
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      rlo_q <= rlo_d;
      tx_q <= tx_d;
      half_q <= half_d;
      push_q <= push_d;
      rsec_q <= rsec_d;
      stat_q <= stat_d;
      addr_q <= addr_d;
      word_q <= word_d;
      fbs_q <= fbs_d;
      cf_q <= cf_d;
      ppr_q <= ppr_d;
      rows_q <= rows_d;
      ovf_q <= ovf_d;
      und_q <= und_d;
      wp_q <= wp_q + PW'(push_ok);
      rp_q <= rp_q + PW'(pop);
      fc_q <= fc_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      fa_q[wp_q] <= addr_q;
      fd_q[wp_q] <= word_q;
    end
  end
endmodule

// File: tb/tb_spi_mem_cmd_bridge.sv
// tb_spi_mem_cmd_bridge: directed and randomized frames against a word-list reference model
// of the command bridge, with a small memory model answering reads.
module tb_spi_mem_cmd_bridge;
  logic clk_sys = 1'b0, reset_n = 1'b0, cs_n = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0;
  logic mem_full = 1'b0, mem_rd_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic [15:0] mem_rdata = '0;
  logic [7:0] tx_data;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic mem_wr_valid, mem_rd_req, frame_buffer_select, color_format, overflow, fifo_empty;
  logic [9:0] pixels_per_row;
  logic [3:0] panel_rows;
  int tests = 0, fails = 0, cyc = 0, rt = 0;
  logic [24:0] wa[$], ea[$], ra[$];
  logic [15:0] wd[$], ed[$];
  int wc[$], rxc[$];
  logic rfe[$];
  logic [7:0] db[$];
  logic [15:0] mem_arr [logic [24:0]];
  logic [15:0] rw;
  bit m_ovf = 0, m_und = 0, m_fbs = 0, cf;
  logic [31:0] a;
  int n;

  spi_mem_cmd_bridge dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_valid(mem_wr_valid), .mem_rd_req(mem_rd_req), .mem_full(mem_full),
    .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid),
    .frame_buffer_select(frame_buffer_select), .color_format(color_format),
    .pixels_per_row(pixels_per_row), .panel_rows(panel_rows), .overflow(overflow),
    .fifo_empty(fifo_empty)
  );

  always #5 clk_sys = ~clk_sys;

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  // Bus monitor plus memory with a fixed read latency of 3 cycles.
  initial forever begin
    @(negedge clk_sys);
    if (mem_wr_valid) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
      mem_arr[mem_addr] = mem_wdata;
    end
    if (mem_rd_req) begin
      ra.push_back(mem_addr);
      rfe.push_back(fifo_empty);
    end
    mem_rd_valid = 1'b0;
    if (rt > 0) begin
      rt--;
      if (rt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rdata = rw;
      end
    end
    if (mem_rd_req) begin
      rt = 3;
      rw = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 16'h0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_sys);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    rxc.push_back(cyc);
    @(posedge clk_sys);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b);
    idle(3);
  endtask

  task automatic open_frame();
    rxc.delete();
    cs_n = 1'b0;
    idle(3);
  endtask

  task automatic close_frame();
    cs_n = 1'b1;
    idle(4);
  endtask

  task automatic txr();
    @(posedge clk_sys);
    #1;
    tx_ready = 1'b1;
    @(posedge clk_sys);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] op, input logic [7:0] val);
    open_frame();
    sb(op);
    sb(val);
    close_frame();
    if (op == 8'h14) m_fbs = val[0];
  endtask

  // Reference: every completed byte (8-bit) or byte pair (16-bit, high first) is one word at the next address.
  task automatic model_words(input logic [24:0] base, input bit c16);
    int k;
    k = c16 ? db.size() / 2 : db.size();
    for (int i = 0; i < k; i++) begin
      ea.push_back(25'(base + 25'(i)));
      ed.push_back(c16 ? {db[2*i], db[2*i+1]} : {8'h00, db[i]});
    end
  endtask

  task automatic write_frame(input logic [31:0] addr, input bit c16);
    open_frame();
    sb(8'h0A);
    for (int i = 3; i >= 0; i--) sb(addr[8*i +: 8]);
    foreach (db[i]) sb(db[i]);
    close_frame();
    model_words(addr[24:0], c16);
  endtask

  task automatic check_writes(input string tag, input int lat);
    for (int i = 0; i < 300 && wa.size() < ea.size(); i++) idle(1);
    idle(4);
    chk({tag, "_count"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      chk({tag, "_addr"}, 32'(wa[i]), 32'(ea[i]));
      chk({tag, "_data"}, 32'(wd[i]), 32'(ed[i]));
    end
    if (lat >= 0 && wc.size() > 0) chk({tag, "_latency"}, wc[0] - rxc[lat], 2);
    wa.delete();
    wd.delete();
    wc.delete();
    ea.delete();
    ed.delete();
  endtask

  task automatic status(input string tag);
    open_frame();
    sb(8'h3C);
    chk(tag, tx_data, {4'b0, m_und, m_ovf, 1'b1, m_fbs});
    m_ovf = 0;
    m_und = 0;
    close_frame();
    chk({tag, "_ovf_clr"}, overflow, 0);
  endtask

  initial begin
    idle(3);
    reset_n = 1'b1;
    idle(2);
    // Dirty some state, then reset in the middle of a write frame with words queued.
    cfg(8'h32, 8'h07);
    chk("rows_pre", panel_rows, 7);
    cfg(8'h14, 8'h01);
    cfg(8'h1E, 8'h01);
    mem_full = 1'b1;
    open_frame();
    sb(8'h0A);
    for (int i = 0; i < 4; i++) sb(8'h00);
    sb(8'h11); sb(8'h22); sb(8'h33); sb(8'h44); sb(8'h55);
    reset_n = 1'b0;
    mem_full = 1'b0;
    #2;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wr_valid", mem_wr_valid, 0);
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_fbs", frame_buffer_select, 0);
    chk("rst_cf", color_format, 0);
    chk("rst_ppr", pixels_per_row, 0);
    chk("rst_rows", panel_rows, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_empty", fifo_empty, 1);
    idle(1);
    reset_n = 1'b1;
    close_frame();
    m_fbs = 0;
    chk("post_rst_writes", wa.size(), 0);
    wa.delete(); wd.delete(); wc.delete();
    // Config registers update on the final byte's edge.
    open_frame();
    sb(8'h28);
    send_byte(8'h03);
    chk("ppr_mid", pixels_per_row, 0);
    idle(3);
    send_byte(8'hFF);
    chk("ppr", pixels_per_row, 10'h3FF);
    close_frame();
    open_frame();
    sb(8'h32);
    send_byte(8'h05);
    chk("rows", panel_rows, 5);
    close_frame();
    open_frame();
    sb(8'h14);
    send_byte(8'h01);
    chk("fbs", frame_buffer_select, 1);
    close_frame();
    m_fbs = 1;
    // 16-bit writes with minimum latency check on the first word.
    cfg(8'h1E, 8'h01);
    chk("cf16", color_format, 1);
    db = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    write_frame(32'h0000_0100, 1);
    check_writes("w16", 6);
    // Backpressure: FIFO_DEPTH accepted, two dropped.
    cfg(8'h1E, 8'h00);
    mem_full = 1'b1;
    db.delete();
    for (int i = 0; i < 10; i++) db.push_back(8'($urandom));
    a = $urandom;
    write_frame(a, 0);
    void'(ea.pop_back()); void'(ea.pop_back());
    void'(ed.pop_back()); void'(ed.pop_back());
    m_ovf = 1;
    idle(5);
    chk("bp_ovf", overflow, 1);
    chk("bp_hold", wa.size(), 0);
    chk("bp_not_empty", fifo_empty, 0);
    mem_full = 1'b0;
    check_writes("bp", -1);
    status("bp_status");
    status("status2");
    // Read after write: the read waits for the queued write to drain.
    cfg(8'h1E, 8'h01);
    mem_full = 1'b1;
    db = '{8'h55, 8'hAA};
    write_frame(32'h0000_0010, 1);
    open_frame();
    sb(8'h0B);
    sb(8'h00); sb(8'h00); sb(8'h00); sb(8'h10);
    idle(10);
    chk("rd_held", ra.size(), 0);
    txr();
    chk("underrun_tx", tx_data, 0);
    m_und = 1;
    mem_full = 1'b0;
    for (int i = 0; i < 100 && ra.size() == 0; i++) idle(1);
    chk("rd_cnt", ra.size(), 1);
    chk("rd_after_empty", rfe.size() > 0 ? rfe[0] : 1'b0, 1);
    chk("rd_addr", ra.size() > 0 ? 32'(ra[0]) : 32'hFFFF_FFFF, 32'h10);
    chk("wr_before_rd", wa.size(), 1);
    idle(8);
    chk("rd_hi", tx_data, 8'h55);
    txr();
    chk("rd_lo", tx_data, 8'hAA);
    txr();
    for (int i = 0; i < 100 && ra.size() < 2; i++) idle(1);
    chk("rd_next", ra.size() > 1 ? 32'(ra[1]) : 32'hFFFF_FFFF, 32'h11);
    close_frame();
    check_writes("raw", -1);
    ra.delete();
    rfe.delete();
    status("und_status");
    // Abort mid-word, address wrap, and a clean decode afterwards.
    db = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    write_frame(32'hFFFF_FFFF, 1);
    check_writes("wrap_abort", -1);
    db = '{8'h11, 8'h22};
    write_frame(32'h0000_0200, 1);
    check_writes("after_abort", -1);
    cfg(8'h32, 8'h09);
    chk("rows_after_abort", panel_rows, 9);
    // Randomized write frames.
    for (int t = 0; t < 4; t++) begin
      cf = 1'($urandom_range(0, 1));
      cfg(8'h1E, {7'b0, cf});
      a = $urandom;
      n = $urandom_range(1, 7);
      db.delete();
      for (int i = 0; i < n; i++) db.push_back(8'($urandom));
      write_frame(a, cf);
      check_writes("rand", -1);
    end
    chk("final_ovf", overflow, 0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
